// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/prefetch stage.
package fetch_pkg;

    localparam int OP_W = 16;
    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

endpackage

// File: rtl/op_fifo.sv
// Small synchronous opcode FIFO holding {pc, opcode} pairs; flush beats push/pop.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !flush;
    assign pop_ok  = pop && !flush && (count_reg != '0);

    // Storage carries no reset; entries are only observed when count_reg says they are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head is read combinationally so a push at t is visible at t+1.
    assign head  = (count_reg == '0) ? '0 : mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch/prefetch: PC, req/ack memory handshake, opcode queue, branch flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       BR,
    input  logic [PC_W-1:0]            br_target,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic                       imem_ack,
    input  logic [OP_W-1:0]            imem_data,
    output logic [OP_W-1:0]            opCode,
    output logic [PC_W-1:0]            op_pc,
    output logic                       op_valid,
    input  logic                       op_take,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t          state_reg, state_next;
    logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PC_W-1:0] imem_addr_reg, imem_addr_next;
    logic            push;
    logic            pop;
    logic [CW-1:0]   post_count;

    // A branch cycle neither pushes nor pops; the flush wins.
    assign push       = (state_reg == REQ) && imem_ack && !BR;
    assign pop        = op_take && op_valid && en && !BR;
    assign post_count = count + CW'(push) - CW'(pop);

    op_fifo #(
        .DEPTH (DEPTH),
        .W     (PC_W + OP_W)
    ) u_op_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (BR),
        .din   ({imem_addr_reg, imem_data}),
        .head  ({op_pc, opCode}),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= RESET_PC;
            imem_addr_reg <= RESET_PC;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            imem_addr_reg <= imem_addr_next;
        end
    end

    // While in REQ, fetch_pc_reg always equals the address on the bus.
    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        imem_addr_next = imem_addr_reg;
        case (state_reg)
            IDLE: begin
                if (BR) begin
                    fetch_pc_next = br_target;
                    if (en) begin
                        state_next     = REQ;
                        imem_addr_next = br_target;
                    end
                end else if (en && (count < DEPTH_C)) begin
                    state_next     = REQ;
                    imem_addr_next = fetch_pc_reg;
                end
            end
            REQ: begin
                if (BR) begin
                    fetch_pc_next = br_target;
                    if (!imem_ack) begin
                        state_next = DISCARD;
                    end else if (en) begin
                        imem_addr_next = br_target;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (imem_ack) begin
                    fetch_pc_next = fetch_pc_reg + PC_W'(1);
                    // The outstanding slot is re-reserved only if the queue still has room.
                    if (en && (post_count < DEPTH_C)) begin
                        imem_addr_next = fetch_pc_reg + PC_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (BR) begin
                    fetch_pc_next = br_target;
                end
                if (imem_ack) begin
                    if (en) begin
                        state_next     = REQ;
                        imem_addr_next = fetch_pc_next;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_req  = (state_reg != IDLE);
    assign imem_addr = imem_addr_reg;
    assign op_valid  = (count != '0);

endmodule
